mini_cpu: RTL and testbench
===========================

Name: mini_cpu

Overview:
- Tiny 8-bit accumulator-style teaching CPU.
- One 16x8 unified program/data memory, two 8-bit registers (eax, ebx) and a 4-bit program counter.
- Executes exactly one instruction per rising edge of `step`, which acts as the single-step clock.
- Architectural state is exported for console tracing; the program is preloaded hierarchically into the `mem` array.

Parameters:
- none (fixed 8-bit data, 4-bit address, 16-entry memory)

Ports:
- step  input  1  clock; one instruction executes per rising edge
- rst  input  1  synchronous active-high reset
- eax  output  8  register A (accumulator)
- ebx  output  8  register B
- pc  output  4  address of next instruction to execute
- mem0  output  8  continuous view of mem[0]
- mem1  output  8  continuous view of mem[1]
- mem2  output  8  continuous view of mem[2]
- mem3  output  8  continuous view of mem[3]

Behaviour:
- Storage
  - Internal array named exactly `mem`, declared reg [7:0] mem [0:15].
  - Must be writable hierarchically (dut.mem[i]) before the first edge.
  - Not cleared by rst and not initialised by the RTL.
- Initial state: eax, ebx and pc are 0 at time zero (initialiser), so benches without rst still work.
- Reset: on a rising step edge with rst=1, eax=0, ebx=0, pc=0; no instruction executes and mem is unchanged. rst has priority over everything.
- Instruction format: op = mem[pc][7:4], k = mem[pc][3:0] (immediate or address). Fetch and execute are combinational from the current pc; all updates commit on the same edge.
- Default next pc = pc+1 mod 16; 15 wraps to 0.
- Opcodes:
  - 0 NOP
  - 1 LDA: eax = {4'h0,k}
  - 2 LDB: ebx = {4'h0,k}
  - 3 LDM: eax = mem[k]
  - 4 STA: mem[k] = eax
  - 5 ADD: eax = eax+ebx, truncated to 8 bits (carry discarded)
  - 6 SUB: eax = eax-ebx mod 256
  - 7 MOV: ebx = eax
  - 8 JMP: pc = k
  - 9 JZ: pc = k if eax==0, else pc+1
  - A LDMB: ebx = mem[k]
  - B STB: mem[k] = ebx
  - C AND: eax = eax & ebx
  - D OR: eax = eax | ebx
  - E XOR: eax = eax ^ ebx
  - F HLT: pc, eax, ebx and mem unchanged; every later step re-executes HLT. Only rst leaves HLT.
- k is ignored by opcodes 0, 5, 6, 7, C, D, E, F.
- Self-modifying code is legal: a store into any address, including pc or pc+1, becomes visible on the next fetch.
- Store and fetch on the same edge: the fetch uses the old memory contents.
- mem0..mem3 reflect stores immediately after the committing edge.
- No flags register; JZ tests eax as it stands at the edge.

Test Plan:
- Reset: run any program, assert rst for one edge -> eax=0, ebx=0, pc=0; mem bytes unchanged.
- Arithmetic/store: mem = 13 24 50 4C F0, step 5 -> trace pc/eax: 1/3, 2/3 (ebx=4), 3/7, 4/7 (mem[12]=7), then pc stays 4 on HLT.
- Wrap: mem = 1F 2F 50 ... -> eax=0x1E after ADD; then a second ADD with ebx=0xFF -> eax=0x1D (carry dropped). Separately, with mem filled with 00, 16 steps -> pc returns to 0.
- Branch: mem = 10 93 F0 F0 ... -> LDA 0 then JZ 3 lands pc=3. Same program with 11 at address 0 -> pc=2.
- Self-modify and view ports: program 1F 42 00 F0 -> STA 2 writes 0x0F into mem[2], mem2 reads 15; the next fetch executes 0F as NOP with pc=3.
- Reset while in HLT: rst=1 for one edge -> pc=0 and execution restarts from mem[0].

Source files
------------

// File: rtl/mini_cpu.sv
// Tiny 8-bit accumulator CPU: one instruction per rising edge of step, fetched
// from a 16x8 unified program/data memory at the current pc.
module mini_cpu (
    input  logic       step,
    input  logic       rst,
    output logic [7:0] eax,
    output logic [7:0] ebx,
    output logic [3:0] pc,
    output logic [7:0] mem0,
    output logic [7:0] mem1,
    output logic [7:0] mem2,
    output logic [7:0] mem3
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDA = 4'h1, OP_LDB = 4'h2, OP_LDM = 4'h3,
        OP_STA  = 4'h4, OP_ADD = 4'h5, OP_SUB = 4'h6, OP_MOV = 4'h7,
        OP_JMP  = 4'h8, OP_JZ  = 4'h9, OP_LDMB = 4'hA, OP_STB = 4'hB,
        OP_AND  = 4'hC, OP_OR  = 4'hD, OP_XOR = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    // Preloaded hierarchically by the environment; never cleared here.
    reg [7:0] mem [0:15];

    logic [7:0] eax_q = 8'h00;
    logic [7:0] ebx_q = 8'h00;
    logic [3:0] pc_q  = 4'h0;
    logic [7:0] eax_d, ebx_d;
    logic [3:0] pc_d;

    logic [7:0] instr;
    opcode_e    op;
    logic [3:0] k;
    logic       mem_we;
    logic [7:0] mem_wdata;

    assign instr = mem[pc_q];
    assign op    = opcode_e'(instr[7:4]);
    assign k     = instr[3:0];

    always_comb begin
        eax_d     = eax_q;
        ebx_d     = ebx_q;
        pc_d      = pc_q + 4'd1;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        unique case (op)
            OP_NOP:  ;
            OP_LDA:  eax_d = {4'h0, k};
            OP_LDB:  ebx_d = {4'h0, k};
            OP_LDM:  eax_d = mem[k];
            OP_STA:  begin mem_we = 1'b1; mem_wdata = eax_q; end
            OP_ADD:  eax_d = eax_q + ebx_q;
            OP_SUB:  eax_d = eax_q - ebx_q;
            OP_MOV:  ebx_d = eax_q;
            OP_JMP:  pc_d  = k;
            OP_JZ:   if (eax_q == 8'h00) pc_d = k;
            OP_LDMB: ebx_d = mem[k];
            OP_STB:  begin mem_we = 1'b1; mem_wdata = ebx_q; end
            OP_AND:  eax_d = eax_q & ebx_q;
            OP_OR:   eax_d = eax_q | ebx_q;
            OP_XOR:  eax_d = eax_q ^ ebx_q;
            OP_HLT:  pc_d  = pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge step) begin
        if (rst) begin
            eax_q <= 8'h00;
            ebx_q <= 8'h00;
            pc_q  <= 4'h0;
        end else begin
            eax_q <= eax_d;
            ebx_q <= ebx_d;
            pc_q  <= pc_d;
        end
    end

    // Fetch above reads the pre-edge contents, so a store never affects its own edge.
    always_ff @(posedge step) begin
        if (!rst && mem_we) begin
            mem[k] <= mem_wdata;
        end
    end

    logic [7:0] view [0:3];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_view
            assign view[gi] = mem[gi];
        end
    endgenerate

    assign mem0 = view[0];
    assign mem1 = view[1];
    assign mem2 = view[2];
    assign mem3 = view[3];
    assign eax  = eax_q;
    assign ebx  = ebx_q;
    assign pc   = pc_q;

endmodule

// File: tb/tb_mini_cpu.sv
// Bench for mini_cpu: table of whole-program vectors with final-state checks,
// plus a per-step scoreboard trace covering HLT hold and reset out of HLT.
module tb_mini_cpu;

    logic       step;
    logic       rst;
    logic [7:0] eax, ebx;
    logic [3:0] pc;
    logic [7:0] mem0, mem1, mem2, mem3;

    mini_cpu dut (
        .step(step), .rst(rst), .eax(eax), .ebx(ebx), .pc(pc),
        .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3)
    );

    initial step = 1'b0;
    always #5 step = ~step;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string            name;
        logic [0:15][7:0] prog;
        int               nsteps;
        logic [3:0]       pc;
        logic [7:0]       eax;
        logic [7:0]       ebx;
        logic [3:0]       addr;
        logic [7:0]       val;
    } vec_t;

    typedef struct {
        logic [3:0] pc;
        logic [7:0] eax;
        logic [7:0] ebx;
    } state_t;

    vec_t   vecs [12];
    state_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge step);
        #1;
    endtask

    function automatic logic [7:0] mem_at(input logic [3:0] a);
        case (a)
            4'd0:    return mem0;
            4'd1:    return mem1;
            4'd2:    return mem2;
            4'd3:    return mem3;
            default: return dut.mem[a];
        endcase
    endfunction

    // Memory is loaded while rst is high; the reset edge leaves it untouched.
    task automatic load(input logic [0:15][7:0] prog);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) dut.mem[i] = prog[i];
        tick();
        rst = 1'b0;
    endtask

    task automatic step_expect(input logic [3:0] p, input logic [7:0] a, input logic [7:0] b);
        state_t e;
        sb.push_back('{pc: p, eax: a, ebx: b});
        tick();
        e = sb.pop_front();
        $display("trace pc=%0d eax=0x%02h ebx=0x%02h", pc, eax, ebx);
        chk("trace_pc", {28'h0, pc}, {28'h0, e.pc});
        chk("trace_eax", {24'h0, eax}, {24'h0, e.eax});
        chk("trace_ebx", {24'h0, ebx}, {24'h0, e.ebx});
    endtask

    initial begin
        rst = 1'b0;
        #1;
        chk("init_pc", {28'h0, pc}, 32'h0);
        chk("init_eax", {24'h0, eax}, 32'h0);
        chk("init_ebx", {24'h0, ebx}, 32'h0);

        vecs[0]  = '{"arith",    128'h13_24_50_4C_F0_00_00_00_00_00_00_00_00_00_00_00, 5,  4'd4, 8'h07, 8'h04, 4'd12, 8'h07};
        vecs[1]  = '{"add_wrap", 128'h1F_2F_50_A8_50_F0_00_00_FF_00_00_00_00_00_00_00, 6,  4'd5, 8'h1D, 8'hFF, 4'd8,  8'hFF};
        vecs[2]  = '{"pc_wrap",  128'h0,                                               16, 4'd0, 8'h00, 8'h00, 4'd0,  8'h00};
        vecs[3]  = '{"jz_taken", 128'h10_93_F0_F0_00_00_00_00_00_00_00_00_00_00_00_00, 2,  4'd3, 8'h00, 8'h00, 4'd1,  8'h93};
        vecs[4]  = '{"jz_not",   128'h11_93_F0_F0_00_00_00_00_00_00_00_00_00_00_00_00, 2,  4'd2, 8'h01, 8'h00, 4'd1,  8'h93};
        vecs[5]  = '{"selfmod",  128'h1F_42_00_F0_00_00_00_00_00_00_00_00_00_00_00_00, 3,  4'd3, 8'h0F, 8'h00, 4'd2,  8'h0F};
        vecs[6]  = '{"sub_wrap", 128'h13_25_60_F0_00_00_00_00_00_00_00_00_00_00_00_00, 3,  4'd3, 8'hFE, 8'h05, 4'd0,  8'h13};
        vecs[7]  = '{"and",      128'h1C_25_C0_F0_00_00_00_00_00_00_00_00_00_00_00_00, 3,  4'd3, 8'h04, 8'h05, 4'd2,  8'hC0};
        vecs[8]  = '{"or",       128'h1C_25_D0_F0_00_00_00_00_00_00_00_00_00_00_00_00, 3,  4'd3, 8'h0D, 8'h05, 4'd2,  8'hD0};
        vecs[9]  = '{"xor",      128'h1C_25_E0_F0_00_00_00_00_00_00_00_00_00_00_00_00, 3,  4'd3, 8'h09, 8'h05, 4'd2,  8'hE0};
        vecs[10] = '{"mov_stb",  128'h1A_70_B8_10_38_F0_00_00_00_00_00_00_00_00_00_00, 6,  4'd5, 8'h0A, 8'h0A, 4'd8,  8'h0A};
        vecs[11] = '{"jmp",      128'h85_00_00_00_00_17_F0_00_00_00_00_00_00_00_00_00, 3,  4'd6, 8'h07, 8'h00, 4'd5,  8'h17};

        for (int v = 0; v < 12; v++) begin
            load(vecs[v].prog);
            for (int s = 0; s < vecs[v].nsteps; s++) tick();
            $display("vector %s pc=%0d eax=0x%02h ebx=0x%02h mem[%0d]=0x%02h",
                     vecs[v].name, pc, eax, ebx, vecs[v].addr, mem_at(vecs[v].addr));
            chk({vecs[v].name, "_pc"},  {28'h0, pc},  {28'h0, vecs[v].pc});
            chk({vecs[v].name, "_eax"}, {24'h0, eax}, {24'h0, vecs[v].eax});
            chk({vecs[v].name, "_ebx"}, {24'h0, ebx}, {24'h0, vecs[v].ebx});
            chk({vecs[v].name, "_mem"}, {24'h0, mem_at(vecs[v].addr)}, {24'h0, vecs[v].val});
        end

        // Step-by-step trace of the arithmetic program, held in HLT.
        load(128'h13_24_50_4C_F0_00_00_00_00_00_00_00_00_00_00_00);
        step_expect(4'd1, 8'h03, 8'h00);
        step_expect(4'd2, 8'h03, 8'h04);
        step_expect(4'd3, 8'h07, 8'h04);
        step_expect(4'd4, 8'h07, 8'h04);
        chk("trace_mem12", {24'h0, dut.mem[12]}, 32'h07);
        step_expect(4'd4, 8'h07, 8'h04);
        step_expect(4'd4, 8'h07, 8'h04);
        step_expect(4'd4, 8'h07, 8'h04);

        // One reset edge out of HLT; memory survives and execution restarts at 0.
        rst = 1'b1;
        step_expect(4'd0, 8'h00, 8'h00);
        rst = 1'b0;
        chk("rst_mem0", {24'h0, mem0}, 32'h13);
        chk("rst_mem12", {24'h0, dut.mem[12]}, 32'h07);
        step_expect(4'd1, 8'h03, 8'h00);
        step_expect(4'd2, 8'h03, 8'h04);

        // Reset mid-program also leaves memory and restarts cleanly.
        rst = 1'b1;
        step_expect(4'd0, 8'h00, 8'h00);
        rst = 1'b0;
        chk("rst_mid_mem1", {24'h0, mem1}, 32'h24);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
